// File: rtl/mmio_console.sv
// LC-3 memory-mapped keyboard/display console: KBSR/KBDR/DSR/DDR behind a
// fixed-latency request/ready handshake, with a keyboard receive FIFO and a display holding register.
module mmio_console #(
  parameter logic [15:0] KBSR_ADDR  = 16'hFE00,
  parameter logic [15:0] KBDR_ADDR  = 16'hFE02,
  parameter logic [15:0] DSR_ADDR   = 16'hFE04,
  parameter logic [15:0] DDR_ADDR   = 16'hFE06,
  parameter int          KBD_DEPTH  = 4,
  parameter int          ACCESS_LAT = 2
) (
  input  logic        i_CLK,
  input  logic        i_Reset_n,
  input  logic [15:0] i_Addr,
  input  logic [15:0] i_WData,
  input  logic        i_Req,
  input  logic        i_RW,
  output logic        o_Sel,
  output logic [15:0] o_RData,
  output logic        o_Ready,
  input  logic        i_Key_Valid,
  input  logic [7:0]  i_Key_Data,
  output logic        o_Key_Ready,
  output logic        o_Disp_Valid,
  output logic [7:0]  o_Disp_Data,
  input  logic        i_Disp_Ready,
  output logic        o_Int
);

  localparam int PW = $clog2(KBD_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (ACCESS_LAT > 2) ? $clog2(ACCESS_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lat_cnt_q, lat_cnt_d;
  logic            hold_q, hold_d;

  logic [KBD_DEPTH-1:0][7:0] mem_q, mem_d;
  logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]   kcnt_q, kcnt_d;
  logic            kie_q, kie_d, kovf_q, kovf_d;
  logic            die_q, die_d, dovf_q, dovf_d;
  logic            disp_valid_q, disp_valid_d;
  logic [7:0]      disp_data_q, disp_data_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            int_q, int_d;

  logic hit_kbsr, hit_kbdr, hit_dsr, hit_ddr;
  logic commit, rd_commit, wr_commit;
  logic full, empty, push, pop, disp_free;

  assign hit_kbsr = (i_Addr == KBSR_ADDR);
  assign hit_kbdr = (i_Addr == KBDR_ADDR);
  assign hit_dsr  = (i_Addr == DSR_ADDR);
  assign hit_ddr  = (i_Addr == DDR_ADDR);
  assign o_Sel    = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr;

  // Access FSM: state register
  always_ff @(posedge i_CLK or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= S_IDLE;
      lat_cnt_q <= '0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      hold_q    <= hold_d;
    end
  end

  // Access FSM: next state. hold_q blocks re-triggering until i_Req drops.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    hold_d    = i_Req & (hold_q | (state_q == S_DONE));
    case (state_q)
      S_IDLE: if (i_Req && !hold_q) begin
        state_d   = (ACCESS_LAT == 1) ? S_DONE : S_WAIT;
        lat_cnt_d = '0;
      end
      S_WAIT: begin
        if (!i_Req)                                state_d = S_IDLE;
        else if (lat_cnt_q == LW'(ACCESS_LAT - 2)) state_d = S_DONE;
        else                                       lat_cnt_d = lat_cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Access FSM: outputs
  always_comb begin
    o_Ready = (state_q == S_DONE);
  end

  // All register side effects land on the edge that enters DONE.
  assign commit    = (state_d == S_DONE);
  assign rd_commit = commit & ~i_RW;
  assign wr_commit = commit & i_RW;

  assign full      = (kcnt_q == CW'(KBD_DEPTH));
  assign empty     = (kcnt_q == '0);
  assign push      = i_Key_Valid & ~full;
  assign pop       = rd_commit & hit_kbdr & ~empty;
  assign disp_free = ~disp_valid_q | i_Disp_Ready;

  always_comb begin
    mem_d  = mem_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    kcnt_d = kcnt_q;
    kie_d  = kie_q;
    kovf_d = kovf_q;
    if (push) begin
      mem_d[wp_q] = i_Key_Data;
      wp_d        = wp_q + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
    if (push && !pop)      kcnt_d = kcnt_q + 1'b1;
    else if (pop && !push) kcnt_d = kcnt_q - 1'b1;
    if (wr_commit && hit_kbsr) begin
      kie_d = i_WData[14];
      if (i_WData[0]) kovf_d = 1'b0;
    end
    if (i_Key_Valid && full) kovf_d = 1'b1;
  end

  // Display slot: a consume and a DDR write on the same edge hand over cleanly.
  always_comb begin
    disp_valid_d = disp_valid_q;
    disp_data_d  = disp_data_q;
    die_d        = die_q;
    dovf_d       = dovf_q;
    if (disp_valid_q && i_Disp_Ready) disp_valid_d = 1'b0;
    if (wr_commit && hit_ddr) begin
      if (disp_free) begin
        disp_data_d  = i_WData[7:0];
        disp_valid_d = 1'b1;
      end else begin
        dovf_d = 1'b1;
      end
    end
    if (wr_commit && hit_dsr) begin
      die_d = i_WData[14];
      if (i_WData[0]) dovf_d = 1'b0;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_commit) begin
      rdata_d = 16'h0000;
      if (hit_kbsr)               rdata_d = {~empty, kie_q, 13'd0, kovf_q};
      else if (hit_kbdr && !empty) rdata_d = {8'h00, mem_q[rp_q]};
      else if (hit_dsr)           rdata_d = {~disp_valid_q, die_q, 13'd0, dovf_q};
      else if (hit_ddr)           rdata_d = {8'h00, disp_data_q};
    end
    int_d = (kie_q & ~empty) | (die_q & ~disp_valid_q);
  end

  always_ff @(posedge i_CLK or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      mem_q        <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
      kcnt_q       <= '0;
      kie_q        <= 1'b0;
      kovf_q       <= 1'b0;
      die_q        <= 1'b0;
      dovf_q       <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= 8'h00;
      rdata_q      <= 16'h0000;
      int_q        <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      kcnt_q       <= kcnt_d;
      kie_q        <= kie_d;
      kovf_q       <= kovf_d;
      die_q        <= die_d;
      dovf_q       <= dovf_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      rdata_q      <= rdata_d;
      int_q        <= int_d;
    end
  end

  assign o_RData      = rdata_q;
  assign o_Key_Ready  = ~full;
  assign o_Disp_Valid = disp_valid_q;
  assign o_Disp_Data  = disp_data_q;
  assign o_Int        = int_q;

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console (ACCESS_LAT=2, KBD_DEPTH=4).
module tb_mmio_console;

  localparam logic [15:0] KBSR = 16'hFE00, KBDR = 16'hFE02, DSR = 16'hFE04, DDR = 16'hFE06;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr, wdata, rdata;
  logic        req, rw, sel, ready;
  logic        kv, kr, dv, drdy, irq;
  logic [7:0]  kd, dd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mmio_console dut (
    .i_CLK(clk), .i_Reset_n(rst_n), .i_Addr(addr), .i_WData(wdata),
    .i_Req(req), .i_RW(rw), .o_Sel(sel), .o_RData(rdata), .o_Ready(ready),
    .i_Key_Valid(kv), .i_Key_Data(kd), .o_Key_Ready(kr),
    .o_Disp_Valid(dv), .o_Disp_Data(dd), .i_Disp_Ready(drdy), .o_Int(irq)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic [15:0] a, input logic w, input logic [15:0] wd,
                        output logic [15:0] rd, output int lat);
    @(negedge clk);
    addr = a; rw = w; wdata = wd; req = 1'b1;
    lat = -1; rd = 16'h0000;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (ready) begin lat = c; rd = rdata; break; end
    end
    req = 1'b0;
    if (lat < 0) begin
      n_tests++; n_fail++;
      $display("FAIL access_timeout addr %h: no ready within 10 cycles", a);
    end
    @(posedge clk); #1;
    chk("ready_one_cycle", {15'd0, ready}, 16'h0000);
    @(negedge clk);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] r; int l;
    access(a, 1'b0, 16'h0000, r, l);
    chk(tag, r, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    logic [15:0] r; int l;
    access(a, 1'b1, d, r, l);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk); kv = 1'b1; kd = b;
    @(negedge clk); kv = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    int l;
    logic saw;
    rst_n = 1'b0; addr = 16'h0000; wdata = 16'h0000; req = 1'b0; rw = 1'b0;
    kv = 1'b0; kd = 8'h00; drdy = 1'b0;
    #1;
    chk("reset_rdata", rdata, 16'h0000);
    chk("reset_flags", {12'd0, ready, dv, irq, kr}, 16'h0001);
    chk("reset_disp_data", {8'h00, dd}, 16'h0000);
    #20 rst_n = 1'b1;

    addr = DDR;     #1 chk("sel_ddr", {15'd0, sel}, 16'h0001);
    addr = 16'hFE08; #1 chk("sel_unmapped", {15'd0, sel}, 16'h0000);
    addr = 16'hFE01; #1 chk("sel_odd", {15'd0, sel}, 16'h0000);

    access(KBSR, 1'b0, 16'h0000, r, l);
    chk("first_latency", 16'(l), 16'd2);
    chk("kbsr_after_reset", r, 16'h0000);
    chk("key_ready_idle", {15'd0, kr}, 16'h0001);

    push(8'h41); push(8'h42);
    rd_chk("kbsr_two", KBSR, 16'h8000);
    rd_chk("kbdr_41", KBDR, 16'h0041);
    rd_chk("kbdr_42", KBDR, 16'h0042);
    rd_chk("kbdr_empty", KBDR, 16'h0000);
    rd_chk("kbsr_drained", KBSR, 16'h0000);

    push(8'h10); push(8'h11); push(8'h12); push(8'h13);
    chk("key_ready_full", {15'd0, kr}, 16'h0000);
    push(8'h14);
    rd_chk("kbsr_ovf", KBSR, 16'h8001);
    wr(KBSR, 16'h0001);
    rd_chk("kbsr_ovf_clr", KBSR, 16'h8000);
    rd_chk("kbdr_10", KBDR, 16'h0010);
    chk("key_ready_after_pop", {15'd0, kr}, 16'h0001);
    rd_chk("kbdr_11", KBDR, 16'h0011);
    rd_chk("kbdr_12", KBDR, 16'h0012);
    rd_chk("kbdr_13", KBDR, 16'h0013);
    rd_chk("kbsr_empty_again", KBSR, 16'h0000);

    wr(DDR, 16'h0058);
    chk("disp_valid_set", {15'd0, dv}, 16'h0001);
    chk("disp_data_58", {8'h00, dd}, 16'h0058);
    rd_chk("dsr_busy", DSR, 16'h0000);
    wr(DDR, 16'h0059);
    rd_chk("dsr_dovf", DSR, 16'h0001);
    chk("disp_data_kept", {8'h00, dd}, 16'h0058);
    @(negedge clk); drdy = 1'b1;
    @(negedge clk); drdy = 1'b0;
    chk("disp_consumed", {15'd0, dv}, 16'h0000);
    rd_chk("dsr_free", DSR, 16'h8001);
    rd_chk("ddr_read", DDR, 16'h0058);

    // DDR write committing on the same edge the display consumes
    wr(DDR, 16'h0060);
    chk("disp_data_60", {8'h00, dd}, 16'h0060);
    @(negedge clk); addr = DDR; rw = 1'b1; wdata = 16'h0061; req = 1'b1;
    @(negedge clk); drdy = 1'b1;
    @(posedge clk); #1;
    chk("same_edge_ready", {15'd0, ready}, 16'h0001);
    chk("same_edge_valid", {15'd0, dv}, 16'h0001);
    chk("same_edge_data", {8'h00, dd}, 16'h0061);
    @(negedge clk); req = 1'b0; drdy = 1'b0;
    @(negedge clk);

    wr(KBSR, 16'h4000);
    @(negedge clk); @(negedge clk);
    chk("int_empty", {15'd0, irq}, 16'h0000);
    push(8'h77);
    @(negedge clk);
    chk("int_raised", {15'd0, irq}, 16'h0001);
    rd_chk("kbdr_77", KBDR, 16'h0077);
    @(negedge clk);
    chk("int_cleared", {15'd0, irq}, 16'h0000);

    wr(16'hFE08, 16'hFFFF);
    rd_chk("unmapped_read", 16'hFE08, 16'h0000);

    // Request withdrawn during WAIT: no ready, no pop
    push(8'h55);
    @(negedge clk); addr = KBDR; rw = 1'b0; req = 1'b1;
    @(negedge clk); req = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (ready) saw = 1'b1;
    end
    chk("abort_no_ready", {15'd0, saw}, 16'h0000);
    rd_chk("abort_kbsr", KBSR, 16'hC000);
    rd_chk("abort_kbdr", KBDR, 16'h0055);

    // Async reset during WAIT
    push(8'h66);
    @(negedge clk); addr = KBSR; rw = 1'b0; req = 1'b1;
    @(posedge clk); #1;
    chk("pre_reset_int", {15'd0, irq}, 16'h0001);
    chk("pre_reset_rdata", rdata, 16'h0055);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_rdata", rdata, 16'h0000);
    chk("midreset_flags", {12'd0, ready, dv, irq, kr}, 16'h0001);
    chk("midreset_disp_data", {8'h00, dd}, 16'h0000);
    req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rd_chk("post_reset_kbsr", KBSR, 16'h0000);
    rd_chk("post_reset_dsr", DSR, 16'h8000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
